// File: rtl/led_status_pkg.sv
// Shared types and field-placement helpers for the calculator LED status driver.
package led_status_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    LAMP = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } mode_e;

  // LSB index of a field packed against the top of an LED bank.
  function automatic int field_lsb(input int bank_w, input int field_w);
    return bank_w - field_w;
  endfunction

  function automatic bit fields_fit(input int bank_w, input int low_w, input int high_w);
    return (low_w + high_w) <= bank_w;
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink phase generator for the error display; phase is the value in effect after the next edge.
module led_blink_timer #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic phase
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          phase_q;

  // Exposing the upcoming phase lets the LED register show the first flash on the entry edge.
  always_comb begin
    count_next = '0;
    phase      = 1'b0;
    if (!enable) begin
      phase = 1'b0;
    end else if (restart) begin
      phase = 1'b1;
    end else if (count == LAST) begin
      phase = ~phase_q;
    end else begin
      count_next = count + CW'(1);
      phase      = phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      phase_q <= 1'b0;
    end else begin
      count   <= count_next;
      phase_q <= phase;
    end
  end

endmodule

// File: rtl/led_status_driver.sv
// Registered LED bank driver for the calculator: power-up lamp test, run display,
// and a latched, blinking error mode with explicit acknowledge.
import led_status_pkg::*;

module led_status_driver #(
  parameter int RED_W       = 18,
  parameter int GRN_W       = 9,
  parameter int STATE_W     = 4,
  parameter int NUM_W       = 5,
  parameter int ONE_W       = 8,
  parameter int FLAG_N      = 3,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int LAMP_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               power_on,
  input  logic               error,
  input  logic               err_clear,
  input  logic [FLAG_N-1:0]  flags,
  input  logic [STATE_W-1:0] state,
  input  logic [NUM_W-1:0]   number,
  input  logic [ONE_W-1:0]   one_val,
  output logic [RED_W-1:0]   red_led,
  output logic [GRN_W-1:0]   green_led,
  output logic [1:0]         mode
);

  localparam int ONE_LSB  = field_lsb(RED_W, ONE_W);
  localparam int FLAG_LSB = field_lsb(GRN_W, FLAG_N);
  localparam int LCW      = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;
  localparam logic [LCW-1:0] LAMP_LAST = LCW'(LAMP_CYCLES - 1);

  if (!fields_fit(RED_W, STATE_W, ONE_W)) begin : g_red_overlap
    $fatal(1, "led_status_driver: STATE_W + ONE_W exceeds RED_W");
  end
  if (!fields_fit(GRN_W, NUM_W, FLAG_N)) begin : g_grn_overlap
    $fatal(1, "led_status_driver: NUM_W + FLAG_N exceeds GRN_W");
  end

  mode_e           cur_mode;
  mode_e           next_mode;
  logic [LCW-1:0]  lamp_cnt;
  logic [LCW-1:0]  lamp_next;
  logic [RED_W-1:0] red_next;
  logic [GRN_W-1:0] green_next;
  logic            blink_phase;

  // Dropping power wins over everything and is what releases a latched error.
  always_comb begin
    next_mode = cur_mode;
    lamp_next = '0;
    if (!power_on) begin
      next_mode = OFF;
    end else begin
      case (cur_mode)
        OFF:  next_mode = LAMP;
        LAMP: begin
          if (error) begin
            next_mode = ERR;
          end else if (lamp_cnt == LAMP_LAST) begin
            next_mode = RUN;
          end else begin
            lamp_next = lamp_cnt + LCW'(1);
          end
        end
        RUN:  if (error) next_mode = ERR;
        ERR:  if (err_clear && !error) next_mode = RUN;
        default: next_mode = OFF;
      endcase
    end
  end

  led_blink_timer #(.DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .reset   (reset),
    .enable  (next_mode == ERR),
    .restart ((next_mode == ERR) && (cur_mode != ERR)),
    .phase   (blink_phase)
  );

  always_comb begin
    red_next   = '0;
    green_next = '0;
    case (next_mode)
      OFF:  red_next[STATE_W-1:0] = state;
      LAMP: begin
        red_next   = '1;
        green_next = '1;
      end
      RUN: begin
        red_next[STATE_W-1:0]           = state;
        red_next[ONE_LSB +: ONE_W]      = one_val;
        green_next[NUM_W-1:0]           = number;
        green_next[FLAG_LSB +: FLAG_N]  = flags;
      end
      ERR: begin
        red_next[STATE_W-1:0]      = state;
        red_next[ONE_LSB +: ONE_W] = {ONE_W{blink_phase}};
      end
      default: red_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_mode  <= OFF;
      lamp_cnt  <= '0;
      red_led   <= '0;
      green_led <= '0;
    end else begin
      cur_mode  <= next_mode;
      lamp_cnt  <= lamp_next;
      red_led   <= red_next;
      green_led <= green_next;
    end
  end

  assign mode = cur_mode;

endmodule

// File: tb/tb_led_status_driver.sv
// Self-checking bench for led_status_driver: cycle-level behavioural model plus
// directed scenarios pinned with hand-computed LED values.
module tb_led_status_driver;

  localparam int BLINK_DIV   = 4;
  localparam int LAMP_CYCLES = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        power_on;
  logic        error;
  logic        err_clear;
  logic [2:0]  flags;
  logic [3:0]  state;
  logic [4:0]  number;
  logic [7:0]  one_val;
  logic [17:0] red_led;
  logic [8:0]  green_led;
  logic [1:0]  mode;

  int n_cmp  = 0;
  int n_fail = 0;

  led_status_driver #(
    .BLINK_DIV   (BLINK_DIV),
    .LAMP_CYCLES (LAMP_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .power_on  (power_on),
    .error     (error),
    .err_clear (err_clear),
    .flags     (flags),
    .state     (state),
    .number    (number),
    .one_val   (one_val),
    .red_led   (red_led),
    .green_led (green_led),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Model state: powered, lamp cycles still to show, error latched and its age in clocks.
  bit m_on        = 1'b0;
  bit m_err       = 1'b0;
  int m_lamp_left = 0;
  int m_err_age   = 0;
  int exp_red;
  int exp_green;
  int exp_mode;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_on = 0; m_err = 0; m_lamp_left = 0; m_err_age = 0;
      end else if (!power_on) begin
        m_on = 0; m_err = 0; m_lamp_left = 0;
      end else if (!m_on) begin
        m_on = 1; m_lamp_left = LAMP_CYCLES;
      end else if (m_err) begin
        if (err_clear && !error) m_err = 0;
        else m_err_age++;
      end else if (error) begin
        m_err = 1; m_err_age = 0; m_lamp_left = 0;
      end else if (m_lamp_left > 0) begin
        m_lamp_left--;
      end
      exp_red = 0; exp_green = 0;
      if (reset) begin
        exp_mode = 0;
      end else if (!m_on) begin
        exp_red = int'(state); exp_mode = 0;
      end else if (m_err) begin
        exp_red = int'(state) + ((((m_err_age / BLINK_DIV) % 2) == 0) ? 255 * 1024 : 0);
        exp_mode = 3;
      end else if (m_lamp_left > 0) begin
        exp_red = (1 << 18) - 1; exp_green = (1 << 9) - 1; exp_mode = 1;
      end else begin
        exp_red   = int'(state) + int'(one_val) * 1024;
        exp_green = int'(number) + int'(flags) * 64;
        exp_mode  = 2;
      end
      #1;
      check_output("model_red", 32'(red_led), 32'(exp_red));
      check_output("model_green", 32'(green_led), 32'(exp_green));
      check_output("model_mode", 32'(mode), 32'(exp_mode));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply_stimulus(input logic po, input logic err, input logic clr);
    power_on  = po;
    error     = err;
    err_clear = clr;
  endtask

  task automatic pin(input string name, input logic [17:0] r, input logic [8:0] g,
                     input logic [1:0] m);
    check_output({name, "_red"}, 32'(red_led), 32'(r));
    check_output({name, "_green"}, 32'(green_led), 32'(g));
    check_output({name, "_mode"}, 32'(mode), 32'(m));
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    flags = 3'b000; state = 4'h0; number = 5'h00; one_val = 8'h00;
    tick(2);
    pin("reset", 18'h00000, 9'h000, 2'd0);

    reset = 1'b0; state = 4'h5;
    tick();
    pin("off_state", 18'h00005, 9'h000, 2'd0);

    apply_stimulus(1'b1, 1'b0, 1'b0);
    number = 5'h13; one_val = 8'hA5; flags = 3'b101;
    tick();
    pin("lamp1", 18'h3FFFF, 9'h1FF, 2'd1);
    tick(2);
    pin("lamp3", 18'h3FFFF, 9'h1FF, 2'd1);
    tick();
    pin("run", 18'h29405, 9'h153, 2'd2);

    apply_stimulus(1'b1, 1'b1, 1'b0);
    tick();
    pin("err_entry", 18'h3FC05, 9'h000, 2'd3);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    tick(3);
    pin("err_on4", 18'h3FC05, 9'h000, 2'd3);
    tick();
    pin("err_off1", 18'h00005, 9'h000, 2'd3);
    tick(3);
    pin("err_off4", 18'h00005, 9'h000, 2'd3);
    tick();
    pin("err_on_again", 18'h3FC05, 9'h000, 2'd3);

    apply_stimulus(1'b1, 1'b1, 1'b1);
    tick();
    pin("clr_blocked", 18'h3FC05, 9'h000, 2'd3);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    tick();
    pin("clr_run", 18'h29405, 9'h153, 2'd2);

    apply_stimulus(1'b1, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    tick();
    pin("power_drop", 18'h00005, 9'h000, 2'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    tick();
    pin("relamp", 18'h3FFFF, 9'h1FF, 2'd1);
    tick(3);
    pin("rerun", 18'h29405, 9'h153, 2'd2);
    state = 4'hA; number = 5'h1F; one_val = 8'h3C; flags = 3'b010;
    tick();
    pin("run_new", 18'h0F00A, 9'h09F, 2'd2);

    #2 reset = 1'b1;
    #1;
    pin("async_reset", 18'h00000, 9'h000, 2'd0);
    tick();
    reset = 1'b0;
    tick();
    pin("post_reset_lamp", 18'h3FFFF, 9'h1FF, 2'd1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    tick();
    pin("lamp_err", 18'h3FC0A, 9'h000, 2'd3);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    tick(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
